// File: rtl/wb_arbiter4_if.sv
// ----------------------------------------------------------------------------
// wb_arbiter4_if
//
// Signal bundle for a 4-master / 1-slave Wishbone arbiter.
//
// Master side (packed per master, master i in slice i):
//   m_cyc[4], m_stb[4], m_we[4]   cycle request, strobe, write enable
//   m_adr[120]                     word address, master i at [30i+29:30i]
//   m_dat_w[128]                   write data,   master i at [32i+31:32i]
//   m_sel[16]                      byte selects, master i at [4i+3:4i]
//   m_dat_r[32]                    read data, broadcast to every master
//   m_ack[4], m_err[4]             per-master acknowledge / timeout error
// Slave side (shared):
//   s_cyc, s_stb, s_we, s_adr[30], s_dat_w[32], s_sel[4]   request
//   s_dat_r[32], s_ack                                       response
// Arbitration status:
//   grant[4]                       registered one-hot owner, 0 when idle
//
// Modports: arbiter (the wb_arbiter4 view), master (the requesting side),
// slave (the shared target).
// ----------------------------------------------------------------------------
interface wb_arbiter4_if;
  logic [3:0]   m_cyc;
  logic [3:0]   m_stb;
  logic [3:0]   m_we;
  logic [119:0] m_adr;
  logic [127:0] m_dat_w;
  logic [15:0]  m_sel;
  logic [31:0]  m_dat_r;
  logic [3:0]   m_ack;
  logic [3:0]   m_err;

  logic         s_cyc;
  logic         s_stb;
  logic         s_we;
  logic [29:0]  s_adr;
  logic [31:0]  s_dat_w;
  logic [3:0]   s_sel;
  logic [31:0]  s_dat_r;
  logic         s_ack;

  logic [3:0]   grant;

  modport arbiter (
    input  m_cyc, m_stb, m_we, m_adr, m_dat_w, m_sel,
    output m_dat_r, m_ack, m_err,
    output s_cyc, s_stb, s_we, s_adr, s_dat_w, s_sel,
    input  s_dat_r, s_ack,
    output grant
  );

  modport master (
    output m_cyc, m_stb, m_we, m_adr, m_dat_w, m_sel,
    input  m_dat_r, m_ack, m_err, grant
  );

  modport slave (
    input  s_cyc, s_stb, s_we, s_adr, s_dat_w, s_sel,
    output s_dat_r, s_ack
  );
endinterface

// File: rtl/wb_arbiter4.sv
// ----------------------------------------------------------------------------
// wb_arbiter4
//
// Round-robin arbiter letting four Wishbone masters share one slave.
// An owner keeps the bus for as long as it holds m_cyc (no preemption).
// A beat that waits TIMEOUT cycles without s_ack is aborted: the owner gets a
// one-cycle m_err pulse while the slave sees s_cyc low for that cycle.
//
// Parameters:
//   TIMEOUT   wait cycles allowed before abort (1..1023)
// Ports:
//   sys_clk   system clock, rising edge
//   sys_rst_n asynchronous active-low reset
//   bus       wb_arbiter4_if.arbiter, all master/slave bus signals + grant
// ----------------------------------------------------------------------------
module wb_arbiter4 #(
  parameter int TIMEOUT = 255
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  wb_arbiter4_if.arbiter  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } state_e;

  // Last counter value at which a stalled beat is still allowed to wait.
  localparam logic [9:0] WAIT_LAST = 10'(TIMEOUT - 1);

  state_e      state_q;
  logic [3:0]  grant_q;
  logic [1:0]  owner_q;     // binary index of the current owner
  logic [1:0]  last_q;      // index granted most recently
  logic [9:0]  wait_q;
  logic [1:0]  next_owner_d;
  logic        any_req;

  // Round-robin search starting at last_q+1; k = 4 wraps back to last_q
  // itself so a lone repeat requester is still found.
  // NOTE: every signal assigned in an always_comb gets a default first,
  // otherwise the untaken paths infer latches.
  always_comb begin
    next_owner_d = last_q;
    any_req      = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!any_req && bus.m_cyc[2'(last_q + 2'(k))]) begin
        next_owner_d = 2'(last_q + 2'(k));
        any_req      = 1'b1;
      end
    end
  end

  // Slave request mux and per-master responses. Everything is forced to
  // zero outside BUSY, so an async reset drops the bus without a clock.
  always_comb begin
    bus.s_cyc   = 1'b0;
    bus.s_stb   = 1'b0;
    bus.s_we    = 1'b0;
    bus.s_adr   = '0;
    bus.s_dat_w = '0;
    bus.s_sel   = '0;
    bus.m_ack   = '0;
    bus.m_err   = '0;
    if (state_q == BUSY) begin
      for (int i = 0; i < 4; i++) begin
        if (owner_q == 2'(i)) begin
          bus.s_cyc   = bus.m_cyc[i];
          bus.s_stb   = bus.m_stb[i];
          bus.s_we    = bus.m_we[i];
          bus.s_adr   = bus.m_adr[30*i +: 30];
          bus.s_dat_w = bus.m_dat_w[32*i +: 32];
          bus.s_sel   = bus.m_sel[4*i +: 4];
          // An ack without a live strobe is not a beat; drop it.
          bus.m_ack[i] = bus.m_cyc[i] & bus.m_stb[i] & bus.s_ack;
        end
      end
    end else if (state_q == ABORT) begin
      bus.m_err = grant_q;
    end
  end

  assign bus.m_dat_r = bus.s_dat_r;
  assign bus.grant   = grant_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= 2'd3;
      wait_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          wait_q <= '0;
          if (any_req) begin
            state_q <= BUSY;
            grant_q <= 4'b0001 << next_owner_d;
            owner_q <= next_owner_d;
            last_q  <= next_owner_d;
          end
        end

        BUSY: begin
          if (!bus.m_cyc[owner_q]) begin
            state_q <= IDLE;
            grant_q <= '0;
            wait_q  <= '0;
          end else if (bus.m_stb[owner_q] && !bus.s_ack) begin
            // Stalled beat; a simultaneous ack takes the else branch and
            // therefore beats the timeout.
            if (wait_q == WAIT_LAST) begin
              state_q <= ABORT;
              wait_q  <= '0;
            end else begin
              wait_q <= wait_q + 10'd1;
            end
          end else begin
            wait_q <= '0;
          end
        end

        ABORT: begin
          wait_q <= '0;
          if (bus.m_cyc[owner_q]) begin
            state_q <= BUSY;
          end else begin
            state_q <= IDLE;
            grant_q <= '0;
          end
        end

        default: begin
          state_q <= IDLE;
          grant_q <= '0;
          wait_q  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter4.sv
// ----------------------------------------------------------------------------
// tb_wb_arbiter4
//
// Directed bench for wb_arbiter4 (TIMEOUT = 8). Inputs change at the falling
// edge; outputs are sampled 1 time unit later, well away from the rising edge.
// ----------------------------------------------------------------------------
module tb_wb_arbiter4;
  localparam int TIMEOUT = 8;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b1;
  int   tests_run = 0;
  int   failures  = 0;

  wb_arbiter4_if bus();

  wb_arbiter4 #(.TIMEOUT(TIMEOUT)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  task automatic clear_inputs();
    bus.m_cyc   = '0;
    bus.m_stb   = '0;
    bus.m_we    = '0;
    bus.m_adr   = '0;
    bus.m_dat_w = '0;
    bus.m_sel   = '0;
    bus.s_dat_r = '0;
    bus.s_ack   = 1'b0;
  endtask

  task automatic setup_master(input int i, input logic [29:0] adr,
                              input logic we, input logic [31:0] dat);
    bus.m_adr[30*i +: 30]   = adr;
    bus.m_we[i]             = we;
    bus.m_dat_w[32*i +: 32] = dat;
    bus.m_sel[4*i +: 4]     = 4'hF;
  endtask

  task automatic apply_reset();
    @(negedge sys_clk);
    clear_inputs();
    sys_rst_n = 1'b0;
    step();
    sys_rst_n = 1'b1;
  endtask

  // Reset asserted with every input active: outputs must still be quiet.
  task automatic test_reset();
    clear_inputs();
    #1 sys_rst_n = 1'b0;
    bus.m_cyc = 4'hF;
    bus.m_stb = 4'hF;
    bus.s_ack = 1'b1;
    setup_master(0, 30'h3AB, 1'b1, 32'hDEAD_BEEF);
    step();
    step();
    #1;
    tests_run++; if (bus.grant !== 4'b0000) begin failures++; $display("FAIL reset_grant: got %b expected %b", bus.grant, 4'b0000); end
    tests_run++; if (bus.s_cyc !== 1'b0 || bus.s_stb !== 1'b0) begin failures++; $display("FAIL reset_s_cyc_stb: got %b%b expected 00", bus.s_cyc, bus.s_stb); end
    tests_run++; if (bus.m_ack !== 4'b0000 || bus.m_err !== 4'b0000) begin failures++; $display("FAIL reset_ack_err: got ack %b err %b expected 0000 0000", bus.m_ack, bus.m_err); end
    tests_run++; if (bus.s_adr !== 30'h0 || bus.s_dat_w !== 32'h0 || bus.s_we !== 1'b0) begin failures++; $display("FAIL reset_s_mux: got adr %h dat %h we %b expected 0", bus.s_adr, bus.s_dat_w, bus.s_we); end
    @(negedge sys_clk);
    clear_inputs();
    sys_rst_n = 1'b1;
    step();
  endtask

  // Master 2 reads 0x100; slave acks in the third bus cycle.
  task automatic test_single_read();
    setup_master(2, 30'h100, 1'b0, 32'h0);
    bus.m_cyc = 4'b0100;
    bus.m_stb = 4'b0100;
    #1;
    tests_run++; if (bus.s_cyc !== 1'b0) begin failures++; $display("FAIL read_latency: got s_cyc %b expected 0 before edge", bus.s_cyc); end
    step();
    #1;
    tests_run++; if (bus.grant !== 4'b0100) begin failures++; $display("FAIL read_grant: got %b expected %b", bus.grant, 4'b0100); end
    tests_run++; if (bus.s_cyc !== 1'b1 || bus.s_stb !== 1'b1 || bus.s_we !== 1'b0) begin failures++; $display("FAIL read_s_ctrl: got cyc %b stb %b we %b expected 1 1 0", bus.s_cyc, bus.s_stb, bus.s_we); end
    tests_run++; if (bus.s_adr !== 30'h100) begin failures++; $display("FAIL read_s_adr: got %h expected %h", bus.s_adr, 30'h100); end
    tests_run++; if (bus.m_ack !== 4'b0000) begin failures++; $display("FAIL read_early_ack: got %b expected 0000", bus.m_ack); end
    step();
    step();
    bus.s_ack   = 1'b1;
    bus.s_dat_r = 32'h1234_0000;
    #1;
    tests_run++; if (bus.m_ack !== 4'b0100) begin failures++; $display("FAIL read_ack: got %b expected %b", bus.m_ack, 4'b0100); end
    tests_run++; if (bus.m_dat_r !== 32'h1234_0000) begin failures++; $display("FAIL read_data: got %h expected %h", bus.m_dat_r, 32'h1234_0000); end
    step();
    bus.s_ack = 1'b0;
    bus.m_cyc = 4'b0000;
    bus.m_stb = 4'b0000;
    #1;
    tests_run++; if (bus.m_ack !== 4'b0000 || bus.s_cyc !== 1'b0) begin failures++; $display("FAIL read_release: got ack %b s_cyc %b expected 0000 0", bus.m_ack, bus.s_cyc); end
    step();
    #1;
    tests_run++; if (bus.grant !== 4'b0000) begin failures++; $display("FAIL read_idle_grant: got %b expected 0000", bus.grant); end
  endtask

  // All four request together after reset: owners 0,1,2,3 with an idle
  // cycle between each.
  task automatic test_contention();
    logic [3:0] exp_grant;
    apply_reset();
    for (int i = 0; i < 4; i++) setup_master(i, 30'(32'h200 + i), 1'b1, 32'hA000_0000 + i);
    bus.m_cyc = 4'hF;
    bus.m_stb = 4'hF;
    step();
    for (int i = 0; i < 4; i++) begin
      exp_grant = 4'b0001 << i;
      bus.s_ack = 1'b1;
      #1;
      tests_run++; if (bus.grant !== exp_grant) begin failures++; $display("FAIL contention_grant%0d: got %b expected %b", i, bus.grant, exp_grant); end
      tests_run++; if (bus.s_adr !== 30'(32'h200 + i) || bus.s_dat_w !== 32'hA000_0000 + i) begin failures++; $display("FAIL contention_mux%0d: got adr %h dat %h", i, bus.s_adr, bus.s_dat_w); end
      tests_run++; if (bus.m_ack !== exp_grant) begin failures++; $display("FAIL contention_ack%0d: got %b expected %b", i, bus.m_ack, exp_grant); end
      step();
      bus.s_ack    = 1'b0;
      bus.m_cyc[i] = 1'b0;
      bus.m_stb[i] = 1'b0;
      step();
      #1;
      tests_run++; if (bus.grant !== 4'b0000) begin failures++; $display("FAIL contention_gap%0d: got %b expected 0000", i, bus.grant); end
      step();
    end
  endtask

  // Master 1 owns the bus for five acked beats while master 0 waits.
  task automatic test_burst_hold();
    setup_master(1, 30'h1111, 1'b1, 32'h5555_AAAA);
    setup_master(0, 30'h0F0, 1'b0, 32'h0);
    bus.m_cyc = 4'b0010;
    bus.m_stb = 4'b0010;
    step();
    bus.m_cyc[0] = 1'b1;
    bus.m_stb[0] = 1'b1;
    bus.s_ack    = 1'b1;
    for (int b = 0; b < 5; b++) begin
      #1;
      tests_run++; if (bus.grant !== 4'b0010 || bus.m_ack !== 4'b0010) begin failures++; $display("FAIL burst_beat%0d: got grant %b ack %b expected 0010 0010", b, bus.grant, bus.m_ack); end
      step();
    end
    bus.s_ack    = 1'b0;
    bus.m_cyc[1] = 1'b0;
    bus.m_stb[1] = 1'b0;
    step();
    #1;
    tests_run++; if (bus.grant !== 4'b0000) begin failures++; $display("FAIL burst_gap: got %b expected 0000", bus.grant); end
    step();
    #1;
    tests_run++; if (bus.grant !== 4'b0001 || bus.s_adr !== 30'h0F0) begin failures++; $display("FAIL burst_next_owner: got grant %b adr %h expected 0001 0f0", bus.grant, bus.s_adr); end
    bus.m_cyc = '0;
    bus.m_stb = '0;
    step();
    step();
  endtask

  // Master 3 is never acked: eight wait cycles, then a one-cycle error.
  task automatic test_timeout();
    setup_master(3, 30'h3333, 1'b0, 32'h0);
    bus.m_cyc = 4'b1000;
    bus.m_stb = 4'b1000;
    step();
    for (int k = 1; k <= 8; k++) begin
      #1;
      tests_run++; if (bus.m_err !== 4'b0000 || bus.s_cyc !== 1'b1) begin failures++; $display("FAIL timeout_wait%0d: got err %b s_cyc %b expected 0000 1", k, bus.m_err, bus.s_cyc); end
      step();
    end
    bus.s_ack = 1'b1;
    #1;
    tests_run++; if (bus.m_err !== 4'b1000) begin failures++; $display("FAIL timeout_err: got %b expected %b", bus.m_err, 4'b1000); end
    tests_run++; if (bus.s_cyc !== 1'b0 || bus.m_ack !== 4'b0000) begin failures++; $display("FAIL timeout_abort_bus: got s_cyc %b ack %b expected 0 0000", bus.s_cyc, bus.m_ack); end
    step();
    bus.s_ack = 1'b0;
    #1;
    tests_run++; if (bus.m_err !== 4'b0000 || bus.s_cyc !== 1'b1 || bus.grant !== 4'b1000) begin failures++; $display("FAIL timeout_resume: got err %b s_cyc %b grant %b expected 0000 1 1000", bus.m_err, bus.s_cyc, bus.grant); end
    bus.m_cyc = '0;
    bus.m_stb = '0;
    step();
    step();
  endtask

  // Ack lands on the eighth wait cycle, where the timeout would fire.
  task automatic test_ack_at_threshold();
    bus.m_cyc = 4'b1000;
    bus.m_stb = 4'b1000;
    step();
    for (int k = 1; k <= 7; k++) begin
      #1;
      tests_run++; if (bus.m_err !== 4'b0000) begin failures++; $display("FAIL thresh_wait%0d: got err %b expected 0000", k, bus.m_err); end
      step();
    end
    bus.s_ack   = 1'b1;
    bus.s_dat_r = 32'hCAFE_0008;
    #1;
    tests_run++; if (bus.m_ack !== 4'b1000 || bus.m_err !== 4'b0000) begin failures++; $display("FAIL thresh_ack: got ack %b err %b expected 1000 0000", bus.m_ack, bus.m_err); end
    step();
    bus.s_ack = 1'b0;
    #1;
    tests_run++; if (bus.m_err !== 4'b0000 || bus.s_cyc !== 1'b1) begin failures++; $display("FAIL thresh_no_abort: got err %b s_cyc %b expected 0000 1", bus.m_err, bus.s_cyc); end
    bus.m_cyc = '0;
    bus.m_stb = '0;
    step();
    step();
  endtask

  // Reset asserted mid-wait must clear the bus before any clock edge.
  task automatic test_async_reset();
    setup_master(1, 30'h0777, 1'b1, 32'h0BAD_F00D);
    bus.m_cyc = 4'b0010;
    bus.m_stb = 4'b0010;
    step();
    step();
    #1;
    tests_run++; if (bus.s_cyc !== 1'b1 || bus.grant !== 4'b0010) begin failures++; $display("FAIL areset_pre: got s_cyc %b grant %b expected 1 0010", bus.s_cyc, bus.grant); end
    #1;
    sys_rst_n = 1'b0;
    bus.s_ack = 1'b1;
    #1;
    tests_run++; if (bus.s_cyc !== 1'b0 || bus.grant !== 4'b0000) begin failures++; $display("FAIL areset_bus: got s_cyc %b grant %b expected 0 0000", bus.s_cyc, bus.grant); end
    tests_run++; if (bus.m_ack !== 4'b0000 || bus.m_err !== 4'b0000) begin failures++; $display("FAIL areset_resp: got ack %b err %b expected 0000 0000", bus.m_ack, bus.m_err); end
    step();
    bus.s_ack = 1'b0;
    bus.m_cyc = 4'hF;
    bus.m_stb = 4'hF;
    sys_rst_n = 1'b1;
    step();
    #1;
    tests_run++; if (bus.grant !== 4'b0001) begin failures++; $display("FAIL areset_first_grant: got %b expected 0001", bus.grant); end
    clear_inputs();
    step();
    step();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_contention();
    test_burst_hold();
    test_timeout();
    test_ack_at_threshold();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
